// File: rtl/store_memory_encoder.sv
// store_memory_encoder
//
// Store-path encoder and in-order store queue between the LSU issue logic and
// the data-memory write port. RISC-V SB/SH/SW requests are turned into a word
// address, lane-replicated write data and byte strobes, then queued and
// drained through a valid/ready handshake. Misaligned or illegal stores are
// consumed without being queued and reported by a registered one-cycle fault
// pulse.
//
// Parameters:
//   DEPTH       store queue entries (power of two, >= 2)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous reset, active-low
//   req_valid   store request present
//   req_ready   queue can accept (!full), 0 while rst_n is low
//   req_type    funct3: 000 SB, 001 SH, 010 SW, others illegal
//   req_addr    byte address
//   req_data    right-aligned store data
//   mem_valid   head entry presented to memory (= !empty)
//   mem_ready   memory accepts the head entry
//   mem_addr    word address of head entry (bits [1:0] = 0)
//   mem_wdata   lane-replicated write data of head entry
//   mem_wstrb   byte write enables of head entry
//   fault       one-cycle pulse after a faulting request was accepted
//   fault_addr  byte address of the most recent faulting request
//   empty       no stores queued
//
// Optional feature, macro STORE_FORWARD_EN:
//   fwd_addr    load address to look up (input)
//   fwd_data    bytes supplied by queued stores, 0 in unsupplied lanes
//   fwd_strb    lanes supplied by queued stores
//   Each lane is taken from the youngest queued store to the same word that
//   writes that lane.

module store_memory_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic        empty
`ifdef STORE_FORWARD_EN
    ,
    input  logic [31:0] fwd_addr,
    output logic [31:0] fwd_data,
    output logic [3:0]  fwd_strb
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Queue control state
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic          r_fault;
    logic [31:0]   r_fault_addr;

    // Queue storage (word address only; the low two bits are always zero)
    logic [29:0]   r_addr_q  [DEPTH];
    logic [31:0]   r_wdata_q [DEPTH];
    logic [3:0]    r_wstrb_q [DEPTH];

    logic          w_full;
    logic          w_accept;
    logic          w_bad;
    logic          w_enq;
    logic          w_deq;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;

    assign w_full    = (r_count == FULL_CNT);
    // Ready comes from the registered count only, so a full queue never
    // accepts even in a cycle where the head is being drained.
    assign req_ready = rst_n && !w_full;
    assign w_accept  = req_valid && req_ready;
    assign w_enq     = w_accept && !w_bad;
    assign w_deq     = mem_valid && mem_ready;

    assign empty      = (r_count == '0);
    assign mem_valid  = !empty;
    assign mem_addr   = {r_addr_q[r_head], 2'b00};
    assign mem_wdata  = r_wdata_q[r_head];
    assign mem_wstrb  = r_wstrb_q[r_head];
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

    // Byte-lane encoding; data is replicated across lanes so the strobe
    // alone selects what memory writes.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0000_0000;
        w_bad   = 1'b0;
        case (req_type)
            3'b000: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_data[7:0]}};
            end
            3'b001: begin
                if (req_addr[0]) begin
                    w_bad = 1'b1;
                end else begin
                    w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{req_data[15:0]}};
                end
            end
            3'b010: begin
                if (req_addr[1:0] != 2'b00) begin
                    w_bad = 1'b1;
                end else begin
                    w_wstrb = 4'b1111;
                    w_wdata = req_data;
                end
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0000_0000;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_fault <= w_accept && w_bad;
            if (w_accept && w_bad) begin
                r_fault_addr <= req_addr;
            end
        end
    end

    // Storage is not reset: entries are only observed through r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr_q[r_tail]  <= req_addr[31:2];
            r_wdata_q[r_tail] <= w_wdata;
            r_wstrb_q[r_tail] <= w_wstrb;
        end
    end

`ifdef STORE_FORWARD_EN
    logic w_unused_fwd_lo;
    assign w_unused_fwd_lo = ^fwd_addr[1:0];

    // Walk entries oldest to youngest so later matches overwrite earlier
    // ones, leaving the youngest writer of each lane.
    always_comb begin
        logic [AW-1:0] idx;
        fwd_data = 32'h0000_0000;
        fwd_strb = 4'b0000;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + AW'(i);
            if ((CW'(i) < r_count) && (r_addr_q[idx] == fwd_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_wstrb_q[idx][b]) begin
                        fwd_data[8*b +: 8] = r_wdata_q[idx][8*b +: 8];
                        fwd_strb[b]        = 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_memory_encoder.sv
module tb_store_memory_encoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        fault;
    logic [31:0] fault_addr;
    logic        empty;
`ifdef STORE_FORWARD_EN
    logic [31:0] fwd_addr;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_strb;
`endif

    always #5 clk = ~clk;

    store_memory_encoder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .fault      (fault),
        .fault_addr (fault_addr),
        .empty      (empty)
`ifdef STORE_FORWARD_EN
        ,
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .fwd_strb   (fwd_strb)
`endif
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t        q[$];      // stores expected in the queue, oldest first
    logic [31:0] fq_a[$];   // expected fault addresses
    int          fq_c[$];   // monitor cycle in which each fault must pulse
    logic [31:0] model_fa = 32'h0;
    int          mon_cyc  = 0;
    int          n_chk    = 0;
    int          n_pass   = 0;
    logic [31:0] tb_fwd   = 32'h5000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, mon_cyc);
    endtask

    // Reference encoding straight from the store-width rules; returns 1 on fault.
    function automatic bit model(input logic [2:0] t, input logic [31:0] a,
                                 input logic [31:0] d, output ent_t e);
        int off = int'(a[1:0]);
        e.a = {a[31:2], 2'b00};
        e.d = 32'h0;
        e.s = 4'h0;
        if (t == 3'd0) begin
            e.s = 4'(1 << off);
            e.d = d[7:0] * 32'h0101_0101;
            return 1'b0;
        end
        if (t == 3'd1 && (off == 0 || off == 2)) begin
            e.s = (off == 0) ? 4'b0011 : 4'b1100;
            e.d = d[15:0] * 32'h0001_0001;
            return 1'b0;
        end
        if (t == 3'd2 && off == 0) begin
            e.s = 4'b1111;
            e.d = d;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input bit rn, input bit v, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d, input bit mr);
        bit   acc;
        ent_t e;
        rst_n = rn; req_valid = v; req_type = t; req_addr = a; req_data = d; mem_ready = mr;
`ifdef STORE_FORWARD_EN
        fwd_addr = tb_fwd;
`endif
        @(negedge clk);
        acc = rn && v && req_ready;
        @(posedge clk);
        if (acc) begin
            if (model(t, a, d, e)) begin
                fq_a.push_back(a);
                fq_c.push_back(mon_cyc + 1);
            end else begin
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input bit mr);
        step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, mr);
    endtask

    // Monitor: compares DUT state against the scoreboard away from the active edge.
    always @(negedge clk) begin
        bit exp_f;
        mon_cyc++;
        if (!rst_n) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            q.delete();
            fq_a.delete();
            fq_c.delete();
            model_fa = 32'h0;
        end else begin
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
`ifdef STORE_FORWARD_EN
            begin
                logic [31:0] ed;
                logic [3:0]  es;
                ed = 32'h0;
                es = 4'h0;
                foreach (q[i]) begin
                    if (q[i].a[31:2] == fwd_addr[31:2]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (q[i].s[b]) begin
                                ed[8*b +: 8] = q[i].d[8*b +: 8];
                                es[b] = 1'b1;
                            end
                        end
                    end
                end
                chk("fwd_data", fwd_data, ed);
                chk("fwd_strb", 32'(fwd_strb), 32'(es));
            end
`endif
            if (mem_valid && q.size() != 0) begin
                chk("mem_addr", mem_addr, q[0].a);
                chk("mem_wdata", mem_wdata, q[0].d);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].s));
                if (mem_ready) void'(q.pop_front());
            end
            exp_f = (fq_c.size() != 0) && (fq_c[0] == mon_cyc);
            chk("fault", 32'(fault), 32'(exp_f));
            if (exp_f) begin
                model_fa = fq_a.pop_front();
                void'(fq_c.pop_front());
            end
            chk("fault_addr", fault_addr, model_fa);
        end
    end

    initial begin
        int r;
        logic [2:0]  t;
        logic [31:0] a;
        req_valid = 0; req_type = 0; req_addr = 0; req_data = 0; mem_ready = 0; rst_n = 0;
`ifdef STORE_FORWARD_EN
        fwd_addr = 32'h5000;
`endif
        repeat (3) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        idle(1'b0);

        // SB at byte 3
        step(1'b1, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // SH + SW stalled until full, push while full, then drain
        step(1'b1, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234, 1'b0);
        step(1'b1, 1'b1, 3'd2, 32'h0000_2004, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 1'b1, 3'd0, 32'h0000_2008, 32'h0000_0077, 1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 3'd0, 32'h0000_200A, 32'h0000_0055, 1'b1);
        step(1'b1, 1'b1, 3'd0, 32'h0000_200A, 32'h0000_0055, 1'b1);
        repeat (4) idle(1'b1);

        // Misaligned SW then illegal type, back to back
        step(1'b1, 1'b1, 3'd2, 32'h0000_3001, 32'h1111_1111, 1'b1);
        step(1'b1, 1'b1, 3'd3, 32'h0000_4000, 32'h2222_2222, 1'b1);
        step(1'b1, 1'b1, 3'd1, 32'h0000_4003, 32'h3333_3333, 1'b1);
        repeat (3) idle(1'b1);

        // Same-lane forwarding: the younger byte wins
        tb_fwd = 32'h0000_5000;
        step(1'b1, 1'b1, 3'd0, 32'h0000_5001, 32'h0000_0011, 1'b0);
        step(1'b1, 1'b1, 3'd0, 32'h0000_5001, 32'h0000_0022, 1'b0);
        idle(1'b0);
        repeat (3) idle(1'b1);

        // Reset with two stores queued
        step(1'b1, 1'b1, 3'd2, 32'h0000_6000, 32'hAAAA_5555, 1'b0);
        step(1'b1, 1'b1, 3'd2, 32'h0000_6004, 32'h5555_AAAA, 1'b0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        repeat (2) idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 3));
            t = (r == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            a = ($urandom_range(0, 1) == 0) ? (32'h0000_5000 + 32'($urandom_range(0, 15))) : $urandom;
            tb_fwd = 32'h0000_5000 + 32'($urandom_range(0, 3) * 4);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), t, a, $urandom,
                 ($urandom_range(0, 9) < 7));
        end

        // Bounded drain
        for (int n = 0; n < 50 && q.size() != 0; n++) idle(1'b1);
        repeat (2) idle(1'b1);
        chk("drain_left", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
